// File: rtl/mul_seq_if.sv
// Operand/product handshake bundle for the sequential multiplier.
// slave modport is the multiplier side; master modport is the producer/consumer side.
// Operands use valid_i/ready_o; the product uses valid_o/ready_i and holds under backpressure.
interface mul_seq_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0]   A_i;
  logic [WIDTH-1:0]   B_i;
  logic               valid_i;
  logic               ready_o;
  logic [2*WIDTH-1:0] P_o;
  logic               valid_o;
  logic               ready_i;
  logic               busy_o;

  modport slave (
    input  A_i, B_i, valid_i, ready_i,
    output ready_o, P_o, valid_o, busy_o
  );

  modport master (
    output A_i, B_i, valid_i, ready_i,
    input  ready_o, P_o, valid_o, busy_o
  );
endinterface

// File: rtl/mul_seq.sv
// Radix-2 shift-add unsigned multiplier, one multiplier bit consumed per cycle.
// Latency: accept edge 0, RUN on edges 1..WIDTH, product valid after edge WIDTH.
// Backpressure: product and valid_o hold in DONE until ready_i; operands accepted only in IDLE.
module mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  mul_seq_if.slave   bus
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PW-1:0]   mcand;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   acc_sum;
  logic [PW-1:0]   prod;
  logic [WIDTH-1:0] mplr;
  logic [CW-1:0]   cnt;
  logic            last;

  // Final iteration: the product register captures this cycle's sum directly.
  assign last    = (cnt == CW'(WIDTH - 1));
  assign acc_sum = mplr[0] ? (acc + mcand) : acc;

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: fixed-length RUN, DONE waits for the consumer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.valid_i) state_nxt = RUN;
      RUN:     if (last)        state_nxt = DONE;
      DONE:    if (bus.ready_i) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // Datapath: load on accept, shift-add in RUN, product register written only on RUN->DONE.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mcand <= '0;
      mplr  <= '0;
      acc   <= '0;
      cnt   <= '0;
      prod  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.valid_i) begin
            mcand <= PW'(bus.A_i);
            mplr  <= bus.B_i;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          acc   <= acc_sum;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt + 1'b1;
          if (last) begin
            prod <= acc_sum;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready_o = (state == IDLE);
  assign bus.valid_o = (state == DONE);
  assign bus.busy_o  = (state != IDLE);
  assign bus.P_o     = prod;
endmodule

// File: tb/tb_mul_seq.sv
// Scoreboard bench for mul_seq: stimulus pushes expected products, a monitor pops on each output handshake.
// Directed vectors with hand-computed products plus latency, backpressure and reset-abort checks.
// Inputs driven #1 after the rising edge; outputs sampled at #1 or on the falling edge.
module tb_mul_seq;
  localparam int W = 8;

  logic clk;
  logic rst_n;
  logic done;
  int   n_checks;
  int   n_fail;
  logic [2*W-1:0] exp_q[$];

  mul_seq_if #(.WIDTH(W)) bus ();

  mul_seq #(.WIDTH(W)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Wait for ready_o, present operands, and pass the accept edge.
  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
    int t;
    t = 0;
    while (!bus.ready_o && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("ready_wait_timeout", 32'(bus.ready_o), 32'd1);
    bus.A_i     = a;
    bus.B_i     = b;
    bus.valid_i = 1'b1;
    exp_q.push_back(16'(a) * 16'(b));
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
  endtask

  // Count edges after the accept edge until valid_o is seen.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.valid_o && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input string name);
    int lat;
    bus.ready_i = 1'b1;
    accept(a, b);
    wait_valid(lat);
    chk({name, "_latency"}, 32'(lat), 32'(W));
    @(posedge clk); #1;
    chk({name, "_idle_after"}, {bus.ready_o, bus.valid_o}, 32'b10);
  endtask

  initial begin
    int lat;
    n_checks    = 0;
    n_fail      = 0;
    done        = 1'b0;
    rst_n       = 1'b0;
    bus.A_i     = '0;
    bus.B_i     = '0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;

    fork
      // Monitor: every output handshake must match the oldest expected product.
      begin
        while (!done) begin
          @(negedge clk);
          if (rst_n && bus.valid_o && bus.ready_i) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_product", 32'(bus.P_o), 32'hFFFF_FFFF);
            end else begin
              chk("product", 32'(bus.P_o), 32'(exp_q.pop_front()));
            end
          end
        end
      end

      // Stimulus.
      begin
        #3;
        chk("rst_in_ready",  32'(bus.ready_o), 32'd1);
        chk("rst_in_valid",  32'(bus.valid_o), 32'd0);
        chk("rst_in_busy",   32'(bus.busy_o),  32'd0);
        chk("rst_in_p",      32'(bus.P_o),     32'd0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_out_state", {bus.ready_o, bus.valid_o, bus.busy_o}, 32'b100);
        chk("rst_out_p",     32'(bus.P_o), 32'd0);

        // 13 x 11 with cycle-exact timing.
        bus.ready_i = 1'b1;
        accept(8'd13, 8'd11);
        chk("t1_busy_edge0", {bus.ready_o, bus.busy_o}, 32'b01);
        repeat (W - 1) @(posedge clk);
        #1;
        chk("t1_valid_edge7", 32'(bus.valid_o), 32'd0);
        @(posedge clk); #1;
        chk("t1_valid_edge8", {bus.valid_o, bus.ready_o}, 32'b10);
        chk("t1_p",           32'(bus.P_o), 32'd143);
        @(posedge clk); #1;
        chk("t1_edge9", {bus.ready_o, bus.valid_o, bus.busy_o}, 32'b100);

        run_op(8'd255, 8'd255, "ff_ff");
        chk("ff_ff_p_held", 32'(bus.P_o), 32'd65025);
        run_op(8'd1,   8'd255, "one_ff");
        run_op(8'd128, 8'd2,   "msb_x2");
        run_op(8'd0,   8'd200, "zero_a");
        run_op(8'd200, 8'd0,   "zero_b");

        // Backpressure: 7 x 9 held for 5 cycles.
        bus.ready_i = 1'b0;
        accept(8'd7, 8'd9);
        wait_valid(lat);
        chk("bp_latency", 32'(lat), 32'(W));
        for (int i = 0; i < 5; i++) begin
          @(posedge clk); #1;
          chk("bp_hold", {bus.valid_o, bus.P_o}, {1'b1, 16'd63});
        end
        bus.ready_i = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", {bus.ready_o, bus.valid_o}, 32'b10);

        // Inputs wiggling during RUN are ignored; held valid_i accepted in first IDLE cycle.
        accept(8'd3, 8'd5);
        for (int i = 0; i < W - 1; i++) begin
          bus.A_i     = 8'(8'h5A + i * 37);
          bus.B_i     = 8'(8'hC3 - i * 11);
          bus.valid_i = i[0];
          @(posedge clk); #1;
        end
        bus.A_i     = 8'd2;
        bus.B_i     = 8'd4;
        bus.valid_i = 1'b1;
        exp_q.push_back(16'd8);
        @(posedge clk); #1;
        chk("tog_valid_edge8", 32'(bus.valid_o), 32'd1);
        chk("tog_p",           32'(bus.P_o), 32'd15);
        @(posedge clk); #1;
        chk("tog_idle_edge9",  {bus.ready_o, bus.valid_o}, 32'b10);
        @(posedge clk); #1;
        chk("tog_accept_edge10", {bus.ready_o, bus.busy_o}, 32'b01);
        bus.valid_i = 1'b0;
        chk("tog_p_kept_in_run", 32'(bus.P_o), 32'd15);
        wait_valid(lat);
        chk("tog_held_latency", 32'(lat), 32'(W));
        @(posedge clk); #1;

        // Reset mid-RUN aborts with no partial result.
        accept(8'd100, 8'd100);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_state", {bus.ready_o, bus.valid_o, bus.busy_o}, 32'b100);
        chk("abort_p",     32'(bus.P_o), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(8'd6, 8'd7, "after_rst");
        chk("after_rst_p", 32'(bus.P_o), 32'd42);

        repeat (2) @(posedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        done = 1'b1;
      end
    join

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
